field_edit_ctrl: RTL and testbench

- Upstream control stage for the BCD field counter in the clock/calendar setting path.
- Turns debounced push-button levels into single-cycle load/step pulses and the field code that configure the counter.
- Walks the user through the six settable fields: hours, minutes, seconds, day, month, year.
- Signals a write-back of each edited field to the RTC interface logic.

---
 rtl/field_edit_ctrl_if.sv | 30 +++
 rtl/field_edit_ctrl.sv | 161 ++++++++++++++++
 tb/tb_field_edit_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/field_edit_ctrl_if.sv
// Button/RTC side of the field edit controller: debounced buttons and RTC data in,
// BCD counter configuration and RTC write-back strobe out.
interface field_edit_ctrl_if;
  logic       btn_edit;
  logic       btn_left;
  logic       btn_right;
  logic       btn_up;
  logic       btn_down;
  logic       fmt24;
  logic [7:0] rtc_data;
  logic [2:0] field_sel;
  logic [2:0] cod;
  logic [7:0] dato;
  logic       load;
  logic       en;
  logic       up;
  logic       down;
  logic       editing;
  logic       commit;

  modport master (
    output btn_edit, btn_left, btn_right, btn_up, btn_down, fmt24, rtc_data,
    input  field_sel, cod, dato, load, en, up, down, editing, commit
  );

  modport slave (
    input  btn_edit, btn_left, btn_right, btn_up, btn_down, fmt24, rtc_data,
    output field_sel, cod, dato, load, en, up, down, editing, commit
  );
endinterface

// File: rtl/field_edit_ctrl.sv
// Edit-mode controller for the clock/calendar setting path: walks six fields,
// loads the BCD counter, issues step pulses with auto-repeat and write-back strobes.
module field_edit_ctrl #(
  parameter int unsigned REPEAT_DELAY = 8,
  parameter int unsigned REPEAT_RATE  = 3
) (
  input logic             clkm,
  input logic             reset,
  field_edit_ctrl_if.slave bus
);

  localparam int unsigned HW = $clog2(REPEAT_DELAY + 1);
  localparam logic [HW-1:0] DLY_V = HW'(REPEAT_DELAY);
  localparam logic [HW-1:0] RPT_V = HW'(REPEAT_DELAY - REPEAT_RATE + 1);

  typedef enum logic [1:0] {IDLE, LOAD, EDIT, COMMIT} state_e;

  state_e          state_q, nxt_state_q;
  logic [2:0]      field_sel_q, nxt_field_q;
  logic [7:0]      dato_q;
  logic            load_q, en_q, up_q, dn_q, editing_q, commit_q;
  logic [HW-1:0]   hold_q;
  logic            fmt24_q;
  logic            edit_bq, left_bq, right_bq, up_bq, dn_bq;

  logic            edit_e, left_e, right_e, up_e, dn_e;
  logic            lr_move, ud_edge, held_same, rpt_tick;
  logic [2:0]      fld_inc, fld_dec;
  logic [HW-1:0]   hold_nxt;

  function automatic logic [2:0] field_map(input logic [2:0] f, input logic f24);
    case (f)
      3'd0:    field_map = f24 ? 3'b010 : 3'b001;
      3'd1:    field_map = 3'b011;
      3'd2:    field_map = 3'b111;
      3'd3:    field_map = 3'b100;
      3'd4:    field_map = 3'b101;
      3'd5:    field_map = 3'b110;
      default: field_map = 3'b000;
    endcase
  endfunction

  always_comb begin
    edit_e    = bus.btn_edit  & ~edit_bq;
    left_e    = bus.btn_left  & ~left_bq;
    right_e   = bus.btn_right & ~right_bq;
    up_e      = bus.btn_up    & ~up_bq;
    dn_e      = bus.btn_down  & ~dn_bq;
    lr_move   = left_e ^ right_e;
    ud_edge   = (bus.btn_up & ~bus.btn_down & up_e) | (bus.btn_down & ~bus.btn_up & dn_e);
    held_same = (bus.btn_up ^ bus.btn_down) & ~ud_edge;
    rpt_tick  = held_same & (hold_q == DLY_V);
    hold_nxt  = (hold_q == DLY_V) ? RPT_V : hold_q + HW'(1);
    fld_inc   = (field_sel_q == 3'd5) ? 3'd0 : field_sel_q + 3'd1;
    fld_dec   = (field_sel_q == 3'd0) ? 3'd5 : field_sel_q - 3'd1;
  end

  // Plain data sample, no reset: cod tracks fmt24 one cycle later, including out of reset.
  always_ff @(posedge clkm) fmt24_q <= bus.fmt24;

  always_ff @(posedge clkm) begin
    if (reset) begin
      state_q     <= IDLE;
      nxt_state_q <= IDLE;
      field_sel_q <= 3'd0;
      nxt_field_q <= 3'd0;
      dato_q      <= 8'h00;
      load_q      <= 1'b0;
      en_q        <= 1'b0;
      up_q        <= 1'b0;
      dn_q        <= 1'b0;
      editing_q   <= 1'b0;
      commit_q    <= 1'b0;
      hold_q      <= '0;
      edit_bq     <= 1'b0;
      left_bq     <= 1'b0;
      right_bq    <= 1'b0;
      up_bq       <= 1'b0;
      dn_bq       <= 1'b0;
    end else begin
      edit_bq  <= bus.btn_edit;
      left_bq  <= bus.btn_left;
      right_bq <= bus.btn_right;
      up_bq    <= bus.btn_up;
      dn_bq    <= bus.btn_down;
      load_q   <= 1'b0;
      en_q     <= 1'b0;
      up_q     <= 1'b0;
      dn_q     <= 1'b0;
      commit_q <= 1'b0;
      case (state_q)
        IDLE: begin
          editing_q <= 1'b0;
          hold_q    <= '0;
          if (edit_e) begin
            field_sel_q <= 3'd0;
            load_q      <= 1'b1;
            state_q     <= LOAD;
          end
        end
        LOAD: begin
          dato_q    <= bus.rtc_data;
          editing_q <= 1'b1;
          hold_q    <= '0;
          state_q   <= EDIT;
        end
        EDIT: begin
          if (edit_e) begin
            commit_q    <= 1'b1;
            nxt_state_q <= IDLE;
            nxt_field_q <= field_sel_q;
            hold_q      <= '0;
            state_q     <= COMMIT;
          end else if (lr_move) begin
            commit_q    <= 1'b1;
            nxt_state_q <= LOAD;
            nxt_field_q <= right_e ? fld_inc : fld_dec;
            hold_q      <= '0;
            state_q     <= COMMIT;
          end else if (ud_edge) begin
            // The edge cycle is hold offset 0, so the register holds offset+1 from here.
            en_q   <= 1'b1;
            up_q   <= bus.btn_up;
            dn_q   <= bus.btn_down;
            hold_q <= HW'(1);
          end else if (held_same) begin
            hold_q <= hold_nxt;
            if (rpt_tick) begin
              en_q <= 1'b1;
              up_q <= bus.btn_up;
              dn_q <= bus.btn_down;
            end
          end else begin
            hold_q <= '0;
          end
        end
        COMMIT: begin
          hold_q      <= '0;
          state_q     <= nxt_state_q;
          field_sel_q <= nxt_field_q;
          if (nxt_state_q == LOAD) load_q    <= 1'b1;
          else                     editing_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // field_sel only settles on entering LOAD, so the RTC value for the new field is
  // passed straight through during the load cycle and held from then on.
  assign bus.dato      = (state_q == LOAD) ? bus.rtc_data : dato_q;
  assign bus.cod       = field_map(field_sel_q, fmt24_q);
  assign bus.field_sel = field_sel_q;
  assign bus.load      = load_q;
  assign bus.en        = en_q;
  assign bus.up        = up_q;
  assign bus.down      = dn_q;
  assign bus.editing   = editing_q;
  assign bus.commit    = commit_q;

endmodule

// File: tb/tb_field_edit_ctrl.sv
// Directed bench for field_edit_ctrl: entry, steps, auto-repeat, field walk, priority, reset abort.
module tb_field_edit_ctrl;
  logic clkm = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  field_edit_ctrl_if bus();

  field_edit_ctrl #(.REPEAT_DELAY(8), .REPEAT_RATE(3)) dut (
    .clkm  (clkm),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clkm = ~clkm;

  logic [7:0] rtc_tab [6];
  logic [2:0] cod_tab [6];
  initial begin
    rtc_tab = '{8'h17, 8'h42, 8'h05, 8'h28, 8'h11, 8'h24};
    cod_tab = '{3'b010, 3'b011, 3'b111, 3'b100, 3'b101, 3'b110};
  end

  // RTC model: presents the stored value of whichever field is selected.
  always_comb bus.rtc_data = (bus.field_sel < 3'd6) ? rtc_tab[bus.field_sel] : 8'hEE;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clkm);
    #1;
  endtask

  task automatic hold_ud(input logic u, input logic d, input int cyc,
                         output int cnt, output logic [15:0] mask);
    cnt  = 0;
    mask = '0;
    bus.btn_up   = u;
    bus.btn_down = d;
    for (int i = 0; i < cyc; i++) begin
      step();
      if (bus.en) begin
        cnt++;
        mask[i] = 1'b1;
      end
    end
    bus.btn_up   = 1'b0;
    bus.btn_down = 1'b0;
    step();
    if (bus.en) cnt++;
  endtask

  int          cnt;
  logic [15:0] mask;

  initial begin
    reset = 1'b1;
    bus.btn_edit = 0; bus.btn_left = 0; bus.btn_right = 0;
    bus.btn_up = 0; bus.btn_down = 0; bus.fmt24 = 1'b1;
    step(); step();
    chk("rst_field", 16'(bus.field_sel), 16'd0);
    chk("rst_cod24", 16'(bus.cod), 16'b010);
    chk("rst_outs", {bus.load, bus.en, bus.up, bus.down, bus.commit, bus.editing}, 16'd0);
    chk("rst_dato", 16'(bus.dato), 16'h00);
    bus.fmt24 = 1'b0;
    step();
    chk("rst_cod12", 16'(bus.cod), 16'b001);
    bus.fmt24 = 1'b1;
    reset = 1'b0;
    step();

    // Edit entry
    bus.btn_edit = 1'b1;
    step();
    chk("entry_load", 16'(bus.load), 16'd1);
    chk("entry_dato", 16'(bus.dato), 16'h17);
    chk("entry_cod", 16'(bus.cod), 16'b010);
    chk("entry_edit0", 16'(bus.editing), 16'd0);
    bus.btn_edit = 1'b0;
    step();
    chk("entry_editing", 16'(bus.editing), 16'd1);
    chk("entry_load_off", 16'(bus.load), 16'd0);
    chk("entry_dato_hold", 16'(bus.dato), 16'h17);

    // Single steps
    bus.btn_up = 1'b1;
    step();
    chk("up_pulse", {bus.en, bus.up, bus.down}, 16'b110);
    bus.btn_up = 1'b0;
    step();
    chk("up_once", 16'(bus.en), 16'd0);
    bus.btn_down = 1'b1;
    step();
    chk("dn_pulse", {bus.en, bus.up, bus.down}, 16'b101);
    bus.btn_down = 1'b0;
    step();
    chk("dn_once", 16'(bus.en), 16'd0);

    // Auto-repeat
    hold_ud(1'b1, 1'b0, 16, cnt, mask);
    chk("rpt_count", 16'(cnt), 16'd4);
    chk("rpt_offsets", mask, 16'h4901);
    hold_ud(1'b1, 1'b1, 16, cnt, mask);
    chk("both_count", 16'(cnt), 16'd0);

    // fmt24 toggling in edit
    bus.fmt24 = 1'b0;
    step();
    chk("fmt12_cod", 16'(bus.cod), 16'b001);
    bus.fmt24 = 1'b1;
    step();
    chk("fmt24_cod", 16'(bus.cod), 16'b010);

    // Field walk to the right, wrapping 5 -> 0
    for (int f = 0; f < 6; f++) begin
      bus.btn_right = 1'b1;
      step();
      chk($sformatf("walk_commit%0d", f), {bus.commit, bus.editing, bus.load}, 16'b110);
      chk($sformatf("walk_cfield%0d", f), 16'(bus.field_sel), 16'(f));
      bus.btn_right = 1'b0;
      step();
      chk($sformatf("walk_load%0d", f), {bus.load, bus.commit, bus.en}, 16'b100);
      chk($sformatf("walk_field%0d", f), 16'(bus.field_sel), 16'((f + 1) % 6));
      chk($sformatf("walk_cod%0d", f), 16'(bus.cod), 16'(cod_tab[(f + 1) % 6]));
      chk($sformatf("walk_dato%0d", f), 16'(bus.dato), 16'(rtc_tab[(f + 1) % 6]));
      step();
    end

    // Left at field 0 wraps to 5
    bus.btn_left = 1'b1;
    step();
    chk("left_commit", {bus.commit, 13'd0, bus.field_sel}, {1'b1, 13'd0, 3'd0});
    bus.btn_left = 1'b0;
    step();
    chk("left_load", {bus.load, 12'd0, bus.field_sel}, {1'b1, 12'd0, 3'd5});
    chk("left_cod", 16'(bus.cod), 16'b110);
    step();

    // Edit and right together: exit wins
    bus.btn_edit = 1'b1; bus.btn_right = 1'b1;
    step();
    chk("exit_commit", {bus.commit, 12'd0, bus.field_sel}, {1'b1, 12'd0, 3'd5});
    bus.btn_edit = 1'b0; bus.btn_right = 1'b0;
    step();
    chk("exit_idle", {bus.editing, bus.load, bus.commit}, 16'd0);
    chk("exit_field", 16'(bus.field_sel), 16'd5);
    bus.btn_up = 1'b1;
    step();
    chk("idle_no_en", {bus.en, bus.load, bus.commit}, 16'd0);
    bus.btn_up = 1'b0;

    // Re-enter, then left+right together
    bus.btn_edit = 1'b1;
    step();
    chk("reenter_load", {bus.load, 12'd0, bus.field_sel}, {1'b1, 12'd0, 3'd0});
    bus.btn_edit = 1'b0;
    step();
    bus.btn_left = 1'b1; bus.btn_right = 1'b1;
    step();
    chk("lr_no_commit", {bus.commit, bus.load, bus.editing}, 16'b001);
    step();
    chk("lr_no_move", {bus.commit, bus.load, 11'd0, bus.field_sel}, 16'd0);
    bus.btn_left = 1'b0; bus.btn_right = 1'b0;
    step();

    // Reset mid-edit with up held, edit held through release
    bus.btn_up = 1'b1;
    step();
    chk("pre_rst_en", 16'(bus.en), 16'd1);
    step();
    reset = 1'b1; bus.btn_edit = 1'b1;
    step();
    chk("midrst_outs", {bus.load, bus.en, bus.up, bus.down, bus.commit, bus.editing}, 16'd0);
    chk("midrst_field", 16'(bus.field_sel), 16'd0);
    chk("midrst_dato", 16'(bus.dato), 16'h00);
    reset = 1'b0; bus.btn_up = 1'b0;
    step();
    chk("post_rst_load", {bus.load, bus.commit, bus.en}, 16'b100);
    bus.btn_edit = 1'b0;
    step();
    chk("post_rst_edit", 16'(bus.editing), 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
